alu_issue_ctrl: RTL and testbench

- Instruction sequencer that sits in front of the 8-bit ALU and drives its one-hot interface: alu_op[11:0], alu_src1[7:0] and alu_src2[7:0].
- Accepts 16-bit instructions over a valid/ready handshake and decodes each opcode to the one-hot alu_op.
- Reads operands from an internal 4x8 register file, issues them to the external combinational ALU, and writes alu_result back to the register file.
- This block is the control/issue end of the ALU interface; the ALU is the execute end.

---
 rtl/alu_issue_ctrl.sv | 121 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Two-state issue sequencer: decodes 16-bit instructions onto the one-hot ALU
// interface and writes the ALU result (or an LI immediate) back into a 4x8 register file.
module alu_issue_ctrl #(
    parameter int NREG = 4,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    output logic [11:0]   alu_op,
    output logic [DW-1:0] alu_src1,
    output logic [DW-1:0] alu_src2,
    input  logic [DW-1:0] alu_result,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] wb_data,
    input  logic [1:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;
    localparam logic [3:0] OP_LI = 4'd12;

    logic [0:0]              state_q, state_d;
    logic [NREG-1:0][DW-1:0] regs_q, regs_d;
    logic [3:0]              op_q, op_d;
    logic [1:0]              rd_q, rd_d;
    logic [DW-1:0]           imm_q, imm_d;
    logic [11:0]             aluOp_q, aluOp_d;
    logic [DW-1:0]           src1_q, src1_d;
    logic [DW-1:0]           src2_q, src2_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [DW-1:0]           wb_q, wb_d;

    // ALU-facing outputs default to zero, so they clear on every edge that lands in IDLE
    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        op_d    = op_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        aluOp_d = '0;
        src1_d  = '0;
        src2_d  = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wb_d    = wb_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    state_d = ISSUE;
                    op_d    = instr[15:12];
                    rd_d    = instr[11:10];
                    imm_d   = instr[DW-1:0];
                    if (instr[15:12] < OP_LI) begin
                        aluOp_d = 12'h001 << instr[15:12];
                        src1_d  = regs_q[instr[9:8]];
                        src2_d  = regs_q[instr[7:6]];
                    end else if (instr[15:12] == OP_LI) begin
                        src2_d = instr[DW-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q < OP_LI) begin
                    regs_d[rd_q] = alu_result;
                    wb_d         = alu_result;
                end else if (op_q == OP_LI) begin
                    regs_d[rd_q] = imm_q;
                    wb_d         = imm_q;
                end else begin
                    err_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            regs_q  <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            aluOp_q <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            aluOp_q <= aluOp_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wb_q    <= wb_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign alu_op      = aluOp_q;
    assign alu_src1    = src1_q;
    assign alu_src2    = src2_q;
    assign done        = done_q;
    assign err         = err_q;
    assign wb_data     = wb_q;
    assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed walk through the issue/writeback scenarios plus
// randomized instructions, checked every cycle against a transaction-level model.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [11:0] alu_op;
    logic [7:0]  alu_src1;
    logic [7:0]  alu_src2;
    logic [7:0]  alu_result;
    logic        done;
    logic        err;
    logic [7:0]  wb_data;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;

    logic [7:0]  mregs [4];
    logic        expReady;
    logic [11:0] expOp;
    logic [7:0]  expS1;
    logic [7:0]  expS2;
    logic        expDone;
    logic        expErr;
    logic [7:0]  expWb;

    logic [11:0] seenOp;
    logic [7:0]  seenS1;
    logic [7:0]  seenS2;

    alu_issue_ctrl #(.NREG(4), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_result(alu_result),
        .done(done), .err(err), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External ALU stand-in: only ADD, SUB, SLT and XOR are implemented
    function automatic logic [7:0] aluModel(input logic [11:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            12'h001: return a + b;
            12'h002: return a - b;
            12'h080: return ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
            12'h400: return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = aluModel(alu_op, alu_src1, alu_src2);

    // Architectural result of an instruction, derived from its opcode number
    function automatic logic [7:0] refResult(input int op, input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        sa = (a > 8'd127) ? int'(a) - 256 : int'(a);
        sb = (b > 8'd127) ? int'(b) - 256 : int'(b);
        if (op == 0)  return 8'((int'(a) + int'(b)) % 256);
        if (op == 1)  return 8'((int'(a) - int'(b) + 256) % 256);
        if (op == 7)  return (sa < sb) ? 8'h01 : 8'h00;
        if (op == 10) return a ^ b;
        return 8'h00;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("instr_ready", 16'(instr_ready), 16'(expReady));
            checkOutput("alu_op", 16'(alu_op), 16'(expOp));
            checkOutput("alu_src1", 16'(alu_src1), 16'(expS1));
            checkOutput("alu_src2", 16'(alu_src2), 16'(expS2));
            checkOutput("done", 16'(done), 16'(expDone));
            checkOutput("err", 16'(err), 16'(expErr));
            checkOutput("wb_data", 16'(wb_data), 16'(expWb));
            checkOutput("dbg_data", 16'(dbg_data), 16'(mregs[dbg_addr]));
        end
    end

    task automatic setIdleExp();
        expReady = 1'b1;
        expOp    = '0;
        expS1    = '0;
        expS2    = '0;
        expDone  = 1'b0;
        expErr   = 1'b0;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        expWb = 8'h00;
        setIdleExp();
    endtask

    task automatic doReset();
        rst = 1'b1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        resetModel();
        checkEn = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            setIdleExp();
            dbg_addr = 2'($urandom_range(0, 3));
        end
    endtask

    // Accept edge, then the writeback edge; returns 1 ns after writeback with done expected high
    task automatic applyStimulus(input logic [15:0] w, input bit holdValid);
        int op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        op = int'(w[15:12]);
        a  = mregs[w[9:8]];
        b  = mregs[w[7:6]];
        instr = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = holdValid;
        expReady = 1'b0;
        expDone  = 1'b0;
        expErr   = 1'b0;
        expOp    = (op < 12) ? (12'h001 << op) : 12'h000;
        expS1    = (op < 12) ? a : 8'h00;
        expS2    = (op < 12) ? b : ((op == 12) ? w[7:0] : 8'h00);
        res      = (op < 12) ? refResult(op, a, b) : w[7:0];
        seenOp = alu_op;
        seenS1 = alu_src1;
        seenS2 = alu_src2;
        dbg_addr = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        setIdleExp();
        expDone = 1'b1;
        if (op <= 12) begin
            mregs[w[11:10]] = res;
            expWb = res;
        end else begin
            expErr = 1'b1;
        end
        dbg_addr = 2'($urandom_range(0, 3));
    endtask

    task automatic checkDbg(input logic [1:0] a, input logic [7:0] lit);
        dbg_addr = a;
        #2;
        checkOutput($sformatf("dbg_r%0d", a), 16'(dbg_data), 16'(lit));
    endtask

    task automatic resetDuringIssue(input logic [15:0] w);
        int op;
        op = int'(w[15:12]);
        instr = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        expReady = 1'b0;
        expDone  = 1'b0;
        expErr   = 1'b0;
        expOp    = (op < 12) ? (12'h001 << op) : 12'h000;
        expS1    = (op < 12) ? mregs[w[9:8]] : 8'h00;
        expS2    = (op < 12) ? mregs[w[7:6]] : 8'h00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
    endtask

    initial begin
        logic [15:0] w;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        dbg_addr = '0;
        doReset();

        for (int a = 0; a < 4; a++) checkDbg(2'(a), 8'h00);
        checkOutput("ready_after_reset", 16'(instr_ready), 16'h0001);

        applyStimulus(16'hC435, 1'b0);
        checkOutput("li1_wb", 16'(wb_data), 16'h0035);
        checkOutput("li1_done", 16'(done), 16'h0001);
        applyStimulus(16'hC80A, 1'b0);
        checkOutput("li2_wb", 16'(wb_data), 16'h000A);
        checkDbg(2'd1, 8'h35);
        checkDbg(2'd2, 8'h0A);

        idleCycles(1);
        applyStimulus(16'h0D80, 1'b0);
        checkOutput("add_op", 16'(seenOp), 16'h0001);
        checkOutput("add_src1", 16'(seenS1), 16'h0035);
        checkOutput("add_src2", 16'(seenS2), 16'h000A);
        checkOutput("add_wb", 16'(wb_data), 16'h003F);
        checkDbg(2'd3, 8'h3F);

        applyStimulus(16'h1580, 1'b0);
        checkOutput("sub_wb", 16'(wb_data), 16'h002B);
        applyStimulus(16'hA180, 1'b0);
        checkOutput("xor_op", 16'(seenOp), 16'h0400);
        checkOutput("xor_wb", 16'(wb_data), 16'h0021);
        checkDbg(2'd1, 8'h2B);
        checkDbg(2'd0, 8'h21);

        applyStimulus(16'hDC00, 1'b1);
        checkOutput("ill_err", 16'(err), 16'h0001);
        checkOutput("ill_done", 16'(done), 16'h0001);
        checkOutput("ill_wb", 16'(wb_data), 16'h0021);
        applyStimulus(16'hDC00, 1'b0);
        checkDbg(2'd3, 8'h3F);

        applyStimulus(16'hC880, 1'b0);
        applyStimulus(16'h7E40, 1'b0);
        checkOutput("slt_op", 16'(seenOp), 16'h0080);
        checkOutput("slt_wb", 16'(wb_data), 16'h0001);
        checkDbg(2'd3, 8'h01);

        idleCycles(1);
        resetDuringIssue(16'h0D80);
        checkOutput("rst_issue_done", 16'(done), 16'h0000);
        checkDbg(2'd3, 8'h00);
        idleCycles(2);

        for (int i = 0; i < 300; i++) begin
            idleCycles($urandom_range(0, 2));
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:12] = 4'd12;
            else if ($urandom_range(0, 1) == 0) w[15:12] = (w[12]) ? 4'd7 : 4'd1;
            if (i == 150) resetDuringIssue(w);
            else applyStimulus(w, 1'($urandom_range(0, 1)));
        end
        idleCycles(2);

        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
